// File: rtl/alu_writeback_stage_pkg.sv
// Opcode and FSM state encodings shared by the ALU write-back stage and its datapath.
package alu_wb_pkg;

    localparam int OP_W    = 3;
    localparam int RF_WA_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MOV = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } wb_state_e;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Command and register-file port bundle; flag_z/flag_c exist only when ALU_FLAGS_EN is defined.
interface alu_writeback_stage_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    import alu_wb_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [OP_W-1:0]     cmd_op;
    logic [ADDR_W-1:0]   cmd_rd;
    logic [ADDR_W-1:0]   cmd_rs1;
    logic [ADDR_W-1:0]   cmd_rs2;
    logic [ADDR_W-1:0]   rf_a1;
    logic [DATA_W-1:0]   rf_rd1;
    logic                rf_we;
    logic [RF_WA_W-1:0]  rf_wa;
    logic [DATA_W-1:0]   rf_wd;
    logic                done;
    logic [DATA_W-1:0]   result;
`ifdef ALU_FLAGS_EN
    logic                flag_z;
    logic                flag_c;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rf_rd1,
        input  cmd_ready, rf_a1, rf_we, rf_wa, rf_wd, done, result, flag_z, flag_c
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rf_rd1,
        output cmd_ready, rf_a1, rf_we, rf_wa, rf_wd, done, result, flag_z, flag_c
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rf_rd1,
        input  cmd_ready, rf_a1, rf_we, rf_wa, rf_wd, done, result
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rf_rd1,
        output cmd_ready, rf_a1, rf_we, rf_wa, rf_wd, done, result
    );
`endif

endinterface

// File: rtl/alu_writeback_stage_alu_core.sv
// Purely combinational ALU: op/A/B -> result plus carry (ADD carry-out, SUB borrow).
module alu_core
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  alu_op_e           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // The extra top bit of the difference is set exactly when A < B.
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = i_a;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OP_SUB: begin
                o_result = w_diff[DATA_W-1:0];
                o_carry  = w_diff[DATA_W];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SHL:  o_result = i_a << i_b[2:0];
            OP_SHR:  o_result = i_a >> i_b[2:0];
            OP_MOV:  o_result = i_a;
            default: o_result = i_a;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Single-port register-file ALU stage: read rs1, read rs2, execute, write back rd. Optional flags: ALU_FLAGS_EN.
// state | meaning: IDLE accept cmd | RD1 addr rs1 | RD2 addr rs2, latch A | EXEC compute | WB write rd
module alu_writeback_stage
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    alu_writeback_stage_if.slave bus
);

    wb_state_e          r_state;
    wb_state_e          w_next;
    alu_op_e            r_op;
    logic [ADDR_W-1:0]  r_rd;
    logic [ADDR_W-1:0]  r_rs1;
    logic [ADDR_W-1:0]  r_rs2;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_result;
    logic [DATA_W-1:0]  w_alu_result;
    logic               w_hs;
`ifdef ALU_FLAGS_EN
    logic               w_alu_carry;
    logic               r_flag_z;
    logic               r_flag_c;
`else
    logic               w_carry_unused;
`endif

    assign w_hs = bus.cmd_valid && (r_state == ST_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_hs) w_next = ST_RD1;
            ST_RD1:  w_next = ST_RD2;
            ST_RD2:  w_next = ST_EXEC;
            ST_EXEC: w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand B is the live read data during EXEC; only the result is registered.
    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (bus.rf_rd1),
        .o_result (w_alu_result),
`ifdef ALU_FLAGS_EN
        .o_carry  (w_alu_carry)
`else
        .o_carry  (w_carry_unused)
`endif
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_ADD;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_a      <= '0;
            r_result <= '0;
`ifdef ALU_FLAGS_EN
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_op  <= alu_op_e'(bus.cmd_op);
                r_rd  <= bus.cmd_rd;
                r_rs1 <= bus.cmd_rs1;
                r_rs2 <= bus.cmd_rs2;
            end
            if (r_state == ST_RD2) begin
                r_a <= bus.rf_rd1;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_alu_result;
`ifdef ALU_FLAGS_EN
                r_flag_z <= (w_alu_result == '0);
                r_flag_c <= w_alu_carry;
`endif
            end
        end
    end

    always_comb begin
        bus.rf_a1 = '0;
        case (r_state)
            ST_RD1:  bus.rf_a1 = r_rs1;
            ST_RD2:  bus.rf_a1 = r_rs2;
            default: bus.rf_a1 = '0;
        endcase
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.rf_we     = (r_state == ST_WB);
    assign bus.done      = (r_state == ST_WB);
    assign bus.rf_wa     = {{(RF_WA_W-ADDR_W){1'b0}}, r_rd};
    assign bus.rf_wd     = r_result;
    assign bus.result    = r_result;
`ifdef ALU_FLAGS_EN
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_c    = r_flag_c;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage with a behavioural synchronous-read register file.
module tb_alu_writeback_stage;
    import alu_wb_pkg::*;

    logic clk;
    logic rst;

    alu_writeback_stage_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    alu_writeback_stage #(.DATA_W(8), .ADDR_W(4)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] regs [16];
    logic       pl_we;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clk) begin
        if (pl_we)
            regs[pl_addr] <= pl_data;
        else if (bus.rf_we)
            regs[bus.rf_wa[3:0]] <= bus.rf_wd;
        bus.rf_rd1 <= regs[bus.rf_a1];
    end

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_we   = 1'b0;
    endtask

    int         obs_lat;
    logic [3:0] obs_a1_rd1, obs_a1_rd2;
    logic [7:0] obs_wa, obs_wd;
    logic       obs_we, obs_done_after, obs_z, obs_c;

    task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2);
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        obs_lat    = 1;
        obs_a1_rd1 = bus.rf_a1;
        tick();
        obs_lat    = 2;
        obs_a1_rd2 = bus.rf_a1;
        while (!bus.done && obs_lat < 10) begin
            tick();
            obs_lat++;
        end
        obs_wa = bus.rf_wa;
        obs_wd = bus.rf_wd;
        obs_we = bus.rf_we;
        obs_z  = 1'b0;
        obs_c  = 1'b0;
`ifdef ALU_FLAGS_EN
        obs_z  = bus.flag_z;
        obs_c  = bus.flag_c;
`endif
        tick();
        obs_done_after = bus.done;
    endtask

    task automatic check_cmd(input string tag, input logic [3:0] rs1, input logic [3:0] rs2,
                             input logic [3:0] rd, input logic [7:0] exp_wd,
                             input logic exp_z, input logic exp_c);
        chk({tag, "_lat"},  obs_lat, 4);
        chk({tag, "_a1r1"}, obs_a1_rd1, rs1);
        chk({tag, "_a1r2"}, obs_a1_rd2, rs2);
        chk({tag, "_we"},   obs_we, 1);
        chk({tag, "_wa"},   obs_wa, {4'h0, rd});
        chk({tag, "_wd"},   obs_wd, exp_wd);
        chk({tag, "_done1"}, obs_done_after, 0);
        chk({tag, "_reg"},  regs[rd], exp_wd);
`ifdef ALU_FLAGS_EN
        chk({tag, "_z"},    obs_z, exp_z);
        chk({tag, "_c"},    obs_c, exp_c);
`else
        if (exp_z && exp_c && obs_z && obs_c) $display("note: flags disabled");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [7:0] t_exp [8] = '{8'h21, 8'h69, 8'h44, 8'hDD, 8'h99, 8'h50, 8'h0C, 8'hC5};
        logic       t_c   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int acc_idx [4];
        int n_acc;
        int n_we;

        n_chk = 0;
        n_pass = 0;
        pl_we = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_rd = '0;
        bus.cmd_rs1 = '0;
        bus.cmd_rs2 = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_ready",  bus.cmd_ready, 1);
        chk("rst_we",     bus.rf_we, 0);
        chk("rst_a1",     bus.rf_a1, 0);
        chk("rst_wa",     bus.rf_wa, 0);
        chk("rst_wd",     bus.rf_wd, 0);
        chk("rst_done",   bus.done, 0);
        chk("rst_result", bus.result, 0);
`ifdef ALU_FLAGS_EN
        chk("rst_z", bus.flag_z, 0);
        chk("rst_c", bus.flag_c, 0);
`endif

        preload(4'd1, 8'h05);
        preload(4'd2, 8'h03);
        issue(OP_ADD, 4'd4, 4'd1, 4'd2);
        check_cmd("add", 4'd1, 4'd2, 4'd4, 8'h08, 1'b0, 1'b0);
        chk("add_result", bus.result, 8'h08);

        preload(4'd1, 8'h03);
        preload(4'd2, 8'h05);
        issue(OP_SUB, 4'd1, 4'd1, 4'd2);
        check_cmd("sub_borrow", 4'd1, 4'd2, 4'd1, 8'hFE, 1'b0, 1'b1);

        preload(4'd1, 8'hFF);
        preload(4'd2, 8'h01);
        issue(OP_ADD, 4'd3, 4'd1, 4'd2);
        check_cmd("add_wrap", 4'd1, 4'd2, 4'd3, 8'h00, 1'b1, 1'b1);

        preload(4'd1, 8'h81);
        preload(4'd2, 8'h09);
        issue(OP_SHL, 4'd5, 4'd1, 4'd2);
        check_cmd("shl_b3", 4'd1, 4'd2, 4'd5, 8'h02, 1'b0, 1'b0);

        preload(4'd6, 8'hC5);
        preload(4'd7, 8'h5C);
        for (int i = 0; i < 8; i++) begin
            issue(t_op[i], 4'd8, 4'd6, 4'd7);
            check_cmd($sformatf("op%0d", i), 4'd6, 4'd7, 4'd8, t_exp[i], 1'b0, t_c[i]);
        end

        issue(OP_ADD, 4'd6, 4'd6, 4'd6);
        check_cmd("alias", 4'd6, 4'd6, 4'd6, 8'h8A, 1'b0, 1'b1);

        preload(4'd9, 8'h10);
        issue(OP_MOV, 4'd2, 4'd9, 4'd0);
        check_cmd("b2b_w", 4'd9, 4'd0, 4'd2, 8'h10, 1'b0, 1'b0);
        issue(OP_MOV, 4'd10, 4'd2, 4'd3);
        check_cmd("b2b_r", 4'd2, 4'd3, 4'd10, 8'h10, 1'b0, 1'b0);

        bus.cmd_op    = OP_MOV;
        bus.cmd_rd    = 4'd11;
        bus.cmd_rs1   = 4'd9;
        bus.cmd_rs2   = 4'd9;
        bus.cmd_valid = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.cmd_ready) begin
                if (n_acc < 4) acc_idx[n_acc] = c;
                n_acc++;
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("tput_accepts", n_acc, 4);
        for (int k = 1; k < 4; k++)
            chk($sformatf("tput_gap%0d", k), acc_idx[k] - acc_idx[k-1], 5);
        tick();
        tick();

        bus.cmd_valid = 1'b1;
        rst = 1'b1;
        tick();
        chk("rstprio_ready", bus.cmd_ready, 1);
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        tick();
        chk("rstprio_idle", bus.cmd_ready, 1);

        preload(4'd12, 8'h77);
        preload(4'd13, 8'h01);
        issue(OP_MOV, 4'd14, 4'd13, 4'd13);
        chk("pre_result", bus.result, 8'h01);
        bus.cmd_op    = OP_ADD;
        bus.cmd_rd    = 4'd12;
        bus.cmd_rs1   = 4'd13;
        bus.cmd_rs2   = 4'd13;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("exec_ready", bus.cmd_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready",  bus.cmd_ready, 1);
        chk("abort_we",     bus.rf_we, 0);
        chk("abort_done",   bus.done, 0);
        chk("abort_result", bus.result, 0);
        chk("abort_wd",     bus.rf_wd, 0);
        chk("abort_wa",     bus.rf_wa, 0);
        chk("abort_a1",     bus.rf_a1, 0);
`ifdef ALU_FLAGS_EN
        chk("abort_z", bus.flag_z, 0);
        chk("abort_c", bus.flag_c, 0);
`endif
        n_we = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.rf_we) n_we++;
        end
        chk("abort_no_we", n_we, 0);
        chk("abort_reg",   regs[12], 8'h77);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
ALU_WRITEBACK_STAGE -- requirements
Module: alu_writeback_stage

Interface
REQ-001 Parameter: DATA_W, 8, operand/result width; SHALL equal register-file data width.
REQ-002 Parameter: ADDR_W, 4, register index width; SHALL equal register-file address width.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: cmd_valid  input  1  command offered.
REQ-006 Port: cmd_ready  output  1  stage can accept a command.
REQ-007 Port: cmd_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MOV.
REQ-008 Port: cmd_rd, cmd_rs1, cmd_rs2  input  ADDR_W each  destination and source register indices.
REQ-009 Port: rf_a1  output  ADDR_W  register-file read address.
REQ-010 Port: rf_rd1  input  DATA_W  register-file read data, valid one cycle after rf_a1 is presented with rf_we=0.
REQ-011 Port: rf_we  output  1; rf_wa  output  8; rf_wd  output  DATA_W  register-file write-enable/address/data.
REQ-012 Port: done  output  1  one-cycle pulse during the write-back cycle.
REQ-013 Port: result  output  DATA_W  last written-back value.
REQ-014 Port: flag_z, flag_c  output  1 each  zero/carry (present only with ALU_FLAGS_EN).

Function
REQ-015 FSM states SHALL be IDLE, RD1, RD2, EXEC, WB; sequence IDLE->RD1->RD2->EXEC->WB->IDLE.
REQ-016 cmd_ready SHALL be 1 only in IDLE; handshake = cmd_valid & cmd_ready at a rising edge; op, rd, rs1, rs2 latched at that edge.
REQ-017 cmd_valid while not ready SHALL be ignored; commands are never queued.
REQ-018 rf_a1 SHALL be rs1 in RD1, rs2 in RD2, 0 otherwise; rf_we SHALL be 0 in every state except WB.
REQ-019 Operand A SHALL be captured from rf_rd1 at the RD2->EXEC edge; operand B SHALL be taken from rf_rd1 during EXEC.
REQ-020 Result SHALL be computed in EXEC and registered at the EXEC->WB edge; arithmetic modulo 2^DATA_W.
REQ-021 SHL/SHR shift A by B[2:0], zero fill; MOV returns A; B ignored for MOV.
REQ-022 In WB: rf_we=1, rf_wa={0,rd} zero-extended to 8 bits, rf_wd=result, done=1, for exactly one cycle.
REQ-023 Latency handshake edge -> WB SHALL be 4 cycles; sustained throughput one command per 5 cycles.
REQ-024 rs1==rs2, rd==rs1 or rd==rs2 SHALL need no special handling (write follows both reads).
REQ-025 Back-to-back commands SHALL see the prior write-back: the earliest RD1 follows WB by one IDLE cycle.
REQ-026 All outputs SHALL decode only from registered state/latched fields; no combinational input-to-output path.

Reset
REQ-027 reset at an edge SHALL force IDLE regardless of state, abort any command without a write, and clear latched fields.
REQ-028 Reset values: cmd_ready=1 after the first post-reset cycle, rf_we=0, rf_a1=0, rf_wa=0, rf_wd=0, done=0, result=0, flag_z=0, flag_c=0.
REQ-029 reset SHALL take priority over a simultaneous handshake.

Configuration
REQ-030 Macro ALU_FLAGS_EN defined: flag_z/flag_c ports exist, updated at the EXEC->WB edge; flag_z=(result==0); flag_c=carry-out for ADD, borrow (A<B) for SUB, 0 otherwise.
REQ-031 ALU_FLAGS_EN undefined: flag ports and flag logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package alu_wb_pkg SHALL hold opcode constants and FSM state encodings.
REQ-033 Sub-module alu_core SHALL be the purely combinational op/A/B -> result(+carry) datapath.

Verification
REQ-034 r1=0x05, r2=0x03, ADD rd=4 -> WB at edge 4 after handshake: rf_wa=0x04, rf_wd=0x08, done pulse 1 cycle.
REQ-035 r1=0x03, r2=0x05, SUB rd=1 (ALU_FLAGS_EN) -> rf_wd=0xFE, flag_c=1, flag_z=0; r1 overwritten after read.
REQ-036 r1=0xFF, r2=0x01, ADD -> rf_wd=0x00, flag_z=1, flag_c=1; SHL r1=0x81, r2=0x09 -> 0x02.
REQ-037 cmd_valid held high continuously -> exactly one accept per 5 cycles, cmd_ready low in RD1..WB.
REQ-038 Command writes r2=0x10, next reads r2 via MOV -> second WB writes 0x10.
REQ-039 reset asserted in EXEC -> no rf_we pulse, next cycle IDLE, all outputs at reset values.
